int_arbiter: RTL and testbench
==============================

INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NSRC, default 4, fixed number of interrupt sources; only 4 is supported.
REQ-002 Parameter EOI_ANY, default 1; the value written to the EOI register is ignored.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 addr  input  [3:2]  register select: 00 MASK, 01 PEND, 10 VECT, 11 EOI.
REQ-006 Din  input  32  CPU write data.
REQ-007 we  input  1  CPU write strobe, 1 cycle per write.
REQ-008 Dout  output  32  CPU read data, combinational from addr.
REQ-009 irq_in  input  [3:0]  IntReq lines from timer devices; index 0 is highest priority.
REQ-010 int_ack  input  1  CPU accepts the interrupt, 1-cycle pulse.
REQ-011 irq_out  output  1  interrupt request to the CPU.

Function
REQ-012 Edge capture: irq_d SHALL register irq_in each cycle; pend[i] SHALL set on the clock where irq_in[i]=1 and irq_d[i]=0.
REQ-013 The MASK register SHALL be 4 bits (1 = enabled), written from Din[3:0] on we with addr=00.
REQ-014 PEND SHALL clear only by writing 1 to that bit (we, addr=01, Din[3:0]) or by arbitration; a set and a clear in the same cycle SHALL leave the bit set.
REQ-015 eligible = pend & MASK; winner = lowest set index of eligible.
REQ-016 The FSM SHALL have states IDLE, REQ and SERVE.
REQ-017 IDLE->REQ SHALL occur on the clock where eligible != 0.
REQ-018 In REQ with int_ack=1, the FSM SHALL latch the winner into vec_id[1:0], clear pend[winner] and go to SERVE, all on the same clock.
REQ-019 In REQ with eligible = 0 (through masking or clearing) and int_ack=0, the FSM SHALL return to IDLE.
REQ-020 If int_ack and eligible = 0 coincide in REQ, the ack SHALL be ignored and the FSM SHALL go to IDLE.
REQ-021 SERVE->IDLE SHALL occur on a write with addr=11; there is no nesting, and new edges only accumulate in PEND during SERVE.
REQ-022 int_ack in IDLE or SERVE SHALL be ignored.
REQ-023 irq_out SHALL be 1 exactly when state=REQ, decoded from the state register.
REQ-024 Latency: an irq_in rise sampled at edge k SHALL set pend at k and assert irq_out after edge k+1, provided the FSM is in IDLE and the source is enabled.
REQ-025 Re-raise: after EOI at edge k, irq_out SHALL re-assert after edge k+1 if any eligible bit remains.
REQ-026 Dout for addr=00 SHALL be {28'b0, MASK}.
REQ-027 Dout for addr=01 SHALL be {28'b0, pend}.
REQ-028 Dout for addr=10 SHALL be {state==SERVE, 28'b0, 1'b0, vec_id}, with bit31 set while in SERVE.
REQ-029 Dout for addr=11 SHALL be 0.
REQ-030 Writes to VECT (addr=10) SHALL have no effect.
REQ-031 Writes to MASK and PEND SHALL take effect at the same clock edge as the FSM evaluation that uses them; the FSM uses pre-edge values.

Reset
REQ-032 While reset=0: MASK=0, pend=0, irq_d=0, vec_id=0, state=IDLE, irq_out=0, Dout reflects the zeroed registers.
REQ-033 Assertion of reset mid-operation (REQ or SERVE) SHALL return to IDLE immediately and discard pending events.
REQ-034 On release with irq_in[i] already 1, pend[i] SHALL set on the first clock (irq_d=0).

Verification
REQ-035 Test 1: MASK=4'b0001, pulse irq_in[0] -> irq_out=1 two edges later; int_ack -> irq_out=0, VECT=0x80000000; EOI -> VECT bit31=0.
REQ-036 Test 2: MASK=4'b1111, irq_in[3] and irq_in[1] rise together -> ack gives vec_id=1, PEND=4'b1000; EOI -> irq_out re-asserts; ack gives vec_id=3.
REQ-037 Test 3: MASK=0, irq_in[2] rises -> PEND=4'b0100, irq_out stays 0; write MASK=4'b0100 -> irq_out=1 after the next edge.
REQ-038 Test 4: state REQ (source 0), write PEND=4'b0001 (clear) -> FSM IDLE, irq_out=0, a later int_ack is ignored.
REQ-039 Test 5: in SERVE, irq_in[0] rises -> PEND bit0=1, irq_out=0 until EOI, then 1.
REQ-040 Test 6: reset=0 while in SERVE with PEND=4'b1010 -> all registers 0 and irq_out=0 asynchronously.

Source files
------------

// File: rtl/int_arbiter_if.sv
// CPU register bus and interrupt lines of the interrupt arbiter.
// master = CPU/platform side, slave = arbiter side.
interface int_arbiter_if;
    logic [3:2]  addr;
    logic [31:0] Din;
    logic        we;
    logic [31:0] Dout;
    logic [3:0]  irq_in;
    logic        int_ack;
    logic        irq_out;

    modport master (
        output addr, Din, we, irq_in, int_ack,
        input  Dout, irq_out
    );

    modport slave (
        input  addr, Din, we, irq_in, int_ack,
        output Dout, irq_out
    );
endinterface

// File: rtl/int_arbiter.sv
// Four-source edge-captured interrupt arbiter, fixed priority
// (source 0 highest), with MASK/PEND/VECT/EOI CPU registers.
module int_arbiter #(
    parameter int NSRC    = 4,
    parameter bit EOI_ANY = 1'b1
) (
    input logic          clk,
    input logic          reset,
    int_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [NSRC-1:0]   mask;
    logic [NSRC-1:0]   pend, pend_n;
    logic [NSRC-1:0]   irq_d;
    logic [1:0]        vec_id;
    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   clr;
    logic [NSRC-1:0]   took;
    logic [1:0]        winner;
    logic              take;
    logic              wr_mask, wr_pend, wr_eoi;

    assign wr_mask  = bus.we && (bus.addr == 2'b00);
    assign wr_pend  = bus.we && (bus.addr == 2'b01);
    assign wr_eoi   = bus.we && (bus.addr == 2'b11)
                   && (EOI_ANY || (bus.Din[1:0] == vec_id));
    assign eligible = pend & mask;
    assign rise     = bus.irq_in & ~irq_d;
    assign clr      = wr_pend ? bus.Din[NSRC-1:0] : '0;

    // Lowest set index of the eligible vector wins.
    always_comb begin
        winner = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 2'(i);
        end
    end

    // Next state; an ack only counts in REQ with something eligible.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (eligible != '0) state_n = REQ;
            end
            REQ: begin
                if (eligible == '0) begin
                    state_n = IDLE;
                end else if (bus.int_ack) begin
                    state_n = SERVE;
                    take    = 1'b1;
                end
            end
            SERVE: begin
                if (wr_eoi) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Pending update: new edges win over CPU or arbitration clears.
    always_comb begin
        took          = '0;
        took[winner]  = take;
        pend_n        = (pend & ~clr & ~took) | rise;
    end

    // State, pending, mask, edge-history and vector registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pend   <= '0;
            mask   <= '0;
            irq_d  <= '0;
            vec_id <= 2'd0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            irq_d <= bus.irq_in;
            if (wr_mask) mask <= bus.Din[NSRC-1:0];
            if (take) vec_id <= winner;
        end
    end

    assign bus.irq_out = (state == REQ);

    // Combinational register read mux.
    always_comb begin
        bus.Dout = 32'd0;
        unique case (bus.addr)
            2'b00: bus.Dout = {28'd0, mask};
            2'b01: bus.Dout = {28'd0, pend};
            2'b10: bus.Dout = {state == SERVE, 28'd0, 1'b0, vec_id};
            2'b11: bus.Dout = 32'd0;
            default: bus.Dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_int_arbiter.sv
// Randomised and directed bench for int_arbiter with a queue
// scoreboard fed by a behavioural model of the register map.
module tb_int_arbiter;
    logic clk;
    logic rst_n;

    int_arbiter_if bus ();

    int_arbiter #(.NSRC(4), .EOI_ANY(1'b1)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [31:0] dout;
        logic [1:0]  addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Abstract model: a set of pending sources, an enable set and a mode.
    int   m_pend, m_mask, m_prev, m_vec;
    int   m_mode;
    logic [3:0] cur_irq;
    logic [1:0] rd_a;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(logic [1:0] a);
        case (a)
            2'd0: return 32'(m_mask);
            2'd1: return 32'(m_pend);
            2'd2: return (m_mode == 2 ? 32'h8000_0000 : 32'd0) | 32'(m_vec);
            default: return 32'd0;
        endcase
    endfunction

    // Apply one cycle of stimulus and predict the post-edge outputs.
    task automatic step(bit r, bit w, logic [1:0] a, logic [31:0] d,
                        logic [3:0] irq, bit ack);
        int elig, took, clr, rise;
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        bus.we      = w;
        bus.addr    = a;
        bus.Din     = d;
        bus.irq_in  = irq;
        bus.int_ack = ack;
        if (!r) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_vec = 0; m_mode = 0;
        end else begin
            elig = m_pend & m_mask;
            rise = int'(irq) & ~m_prev & 15;
            clr  = (w && a == 2'd1) ? int'(d[3:0]) : 0;
            took = 0;
            if (m_mode == 0) begin
                if (elig != 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (elig == 0) m_mode = 0;
                else if (ack) begin
                    for (int i = 3; i >= 0; i--)
                        if ((elig >> i) & 1) m_vec = i;
                    took   = 1 << m_vec;
                    m_mode = 2;
                end
            end else if (w && a == 2'd3) begin
                m_mode = 0;
            end
            m_pend = (m_pend & ~clr & ~took & 15) | rise;
            if (w && a == 2'd0) m_mask = int'(d[3:0]);
            m_prev = int'(irq);
        end
        e.irq  = (m_mode == 1);
        e.addr = a;
        e.dout = m_read(a);
        q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, rd_a, 32'd0, cur_irq, 1'b0);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        step(1'b1, 1'b1, a, d, cur_irq, 1'b0);
    endtask

    task automatic ack();
        step(1'b1, 1'b0, rd_a, 32'd0, cur_irq, 1'b1);
    endtask

    task automatic pulse(logic [3:0] v);
        cur_irq = v;
        idle(1);
        cur_irq = 4'd0;
    endtask

    // Monitor: compare every presented post-edge output with the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("irq_out", 32'(bus.irq_out), 32'(e.irq));
                check($sformatf("dout_a%0d", e.addr), bus.Dout, e.dout);
            end
        end
    end

    initial begin
        logic [3:0] ri;
        rst_n = 1'b0;
        bus.we = 1'b0; bus.addr = 2'd0; bus.Din = 32'd0;
        bus.irq_in = 4'd0; bus.int_ack = 1'b0;
        cur_irq = 4'd0; rd_a = 2'd2;
        m_pend = 0; m_mask = 0; m_prev = 0; m_vec = 0; m_mode = 0;
        #1;
        check("rst_irq_out", 32'(bus.irq_out), 32'd0);
        check("rst_dout", bus.Dout, 32'd0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0);

        // single source, ack, EOI
        wr(2'd0, 32'h1);
        pulse(4'b0001);
        idle(2);
        ack();
        idle(1);
        wr(2'd3, 32'h0);
        idle(2);

        // two simultaneous sources, re-raise after EOI
        wr(2'd0, 32'hF);
        pulse(4'b1010);
        idle(2);
        ack();
        rd_a = 2'd1; idle(1); rd_a = 2'd2;
        wr(2'd3, 32'h0);
        idle(2);
        ack();
        wr(2'd3, 32'h0);
        idle(1);

        // masked edge stays pending, unmasking raises
        wr(2'd0, 32'h0);
        rd_a = 2'd1; pulse(4'b0100); idle(1); rd_a = 2'd2;
        wr(2'd0, 32'h4);
        idle(2);
        ack();
        wr(2'd3, 32'h0);

        // software clear while requesting, later ack ignored
        wr(2'd0, 32'h1);
        pulse(4'b0001);
        idle(2);
        wr(2'd1, 32'h1);
        idle(2);
        ack();
        idle(2);

        // set and clear of the same bit in one cycle keeps it set
        rd_a = 2'd1;
        step(1'b1, 1'b1, 2'd1, 32'hF, 4'b0100, 1'b0);
        idle(1);
        wr(2'd1, 32'hF);
        rd_a = 2'd2;

        // edge during SERVE waits for EOI
        pulse(4'b0001);
        idle(2);
        ack();
        pulse(4'b0001);
        idle(3);
        wr(2'd3, 32'h0);
        idle(2);
        ack();
        wr(2'd3, 32'h0);

        // async reset in SERVE with PEND=1010
        wr(2'd0, 32'hF);
        pulse(4'b0001);
        idle(2);
        ack();
        rd_a = 2'd1; pulse(4'b1010); idle(1);
        step(1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0);
        #1;
        check("async_irq_out", 32'(bus.irq_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #0.5;
            check($sformatf("async_dout_a%0d", a), bus.Dout, 32'd0);
        end
        bus.addr = 2'd0;
        // release with a line already high: pends on first edge
        step(1'b1, 1'b0, 2'd1, 32'd0, 4'b0100, 1'b0);
        cur_irq = 4'd0;
        idle(2);

        // randomised traffic
        ri = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            bit r, w, k;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) ri[b] = ~ri[b];
            r = ($urandom_range(0, 299) != 0);
            w = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 2) == 0);
            step(r, w, 2'($urandom_range(0, 3)), $urandom, ri, k);
        end

        repeat (2) @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
